// File: rtl/pattern_gen.sv
// pattern_gen: host-loaded waveform buffer replayed MSB-first on output_pin at div+1 clocks per bit.
// Optional: define PATGEN_ONESHOT_EN to add command 0x04 (play the buffer once, then reply 0xD0).
module pattern_gen #(
    parameter int DEPTH_LOG2 = 8,
    parameter int DIV_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    input  logic       tx_busy,
    output logic       output_pin,
    output logic       running
);
    localparam int AW    = DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STOP = 8'h03;
    localparam logic [7:0] ACK_OK   = 8'hA5;
    localparam logic [7:0] ACK_ERR  = 8'hEE;

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DIVL, S_DIVH, S_PLAY} state_t;
    state_t state_reg, state_next;

    logic [LW-1:0]    len_reg, wr_cnt_reg, len_new;
    logic             loaded_reg;
    logic [DIV_W-1:0] div_reg, div_cnt_reg;
    logic [7:0]       div_lo_reg;
    logic             running_reg, output_pin_reg, first_reg;
    logic [7:0]       cur_byte_reg, rd_data_reg;
    logic [2:0]       bit_idx_reg;
    logic [AW-1:0]    byte_idx_reg, last_idx, next_idx, rd_addr;
    logic             pend_reg, new_tx_reg;
    logic [7:0]       pend_data_reg, tx_data_reg;
    logic [7:0]       mem [DEPTH];

    logic       reply_valid, mem_we, start_play, stop_play, load_cmd, finish_play, last_wr;
    logic [7:0] reply_byte;

    assign tx_data     = tx_data_reg;
    assign new_tx_data = new_tx_reg;
    assign output_pin  = output_pin_reg;
    assign running     = running_reg;

    // L+1, clipped to the buffer depth
    always_comb begin
        if (32'(rx_data) >= 32'(DEPTH - 1))
            len_new = LW'(DEPTH);
        else
            len_new = LW'(32'(rx_data) + 32'd1);
    end

    assign last_idx = AW'(len_reg - LW'(1));
    assign next_idx = (byte_idx_reg == last_idx) ? '0 : byte_idx_reg + AW'(1);
    assign rd_addr  = start_play ? '0 : next_idx;
    assign last_wr  = (wr_cnt_reg == len_reg - LW'(1));

`ifdef PATGEN_ONESHOT_EN
    localparam logic [7:0] CMD_ONESHOT = 8'h04;
    localparam logic [7:0] ACK_DONE    = 8'hD0;
    logic oneshot_reg, cmd_oneshot_reg;

    assign finish_play = oneshot_reg && running_reg && !first_reg && (div_cnt_reg == '0) &&
                         (bit_idx_reg == 3'd0) && (byte_idx_reg == last_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            oneshot_reg     <= 1'b0;
            cmd_oneshot_reg <= 1'b0;
        end else begin
            if ((state_reg == S_IDLE || state_reg == S_PLAY) && new_rx_data) begin
                if (rx_data == CMD_RUN)
                    cmd_oneshot_reg <= 1'b0;
                else if (rx_data == CMD_ONESHOT)
                    cmd_oneshot_reg <= 1'b1;
            end
            if (start_play)
                oneshot_reg <= cmd_oneshot_reg;
        end
    end
`else
    assign finish_play = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        reply_valid = 1'b0;
        reply_byte  = ACK_OK;
        mem_we      = 1'b0;
        start_play  = 1'b0;
        stop_play   = 1'b0;
        load_cmd    = 1'b0;
`ifdef PATGEN_ONESHOT_EN
        // a command decoded in the same cycle overrides the completion reply
        if (finish_play) begin
            reply_valid = 1'b1;
            reply_byte  = ACK_DONE;
            if (state_reg == S_PLAY)
                state_next = S_IDLE;
        end
`endif
        case (state_reg)
            S_IDLE, S_PLAY: begin
                if (new_rx_data) begin
                    case (rx_data)
                        CMD_LOAD: begin
                            state_next = S_LEN;
                            stop_play  = 1'b1;
                            load_cmd   = 1'b1;
                        end
                        CMD_RUN: state_next = S_DIVL;
`ifdef PATGEN_ONESHOT_EN
                        CMD_ONESHOT: state_next = S_DIVL;
`endif
                        CMD_STOP: begin
                            state_next  = S_IDLE;
                            stop_play   = 1'b1;
                            reply_valid = 1'b1;
                            reply_byte  = ACK_OK;
                        end
                        default: begin
                            reply_valid = 1'b1;
                            reply_byte  = ACK_ERR;
                        end
                    endcase
                end
            end
            S_LEN: if (new_rx_data) state_next = S_DATA;
            S_DATA: begin
                if (new_rx_data) begin
                    mem_we = 1'b1;
                    if (last_wr) begin
                        state_next  = S_IDLE;
                        reply_valid = 1'b1;
                        reply_byte  = ACK_OK;
                    end
                end
            end
            S_DIVL: if (new_rx_data) state_next = S_DIVH;
            S_DIVH: begin
                if (new_rx_data) begin
                    reply_valid = 1'b1;
                    if (loaded_reg) begin
                        state_next = S_PLAY;
                        start_play = 1'b1;
                        reply_byte = ACK_OK;
                    end else begin
                        state_next = S_IDLE;
                        reply_byte = ACK_ERR;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Buffer RAM: one write port for loading, one registered read port for prefetch.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_cnt_reg[AW-1:0]] <= rx_data;
        rd_data_reg <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            len_reg    <= '0;
            wr_cnt_reg <= '0;
            loaded_reg <= 1'b0;
            div_lo_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_LEN && new_rx_data) begin
                len_reg    <= len_new;
                wr_cnt_reg <= '0;
            end
            if (mem_we)
                wr_cnt_reg <= wr_cnt_reg + LW'(1);
            if (load_cmd)
                loaded_reg <= 1'b0;
            else if (mem_we && last_wr)
                loaded_reg <= 1'b1;
            if (state_reg == S_DIVL && new_rx_data)
                div_lo_reg <= rx_data;
        end
    end

    // Playback: first_reg covers the cycle where byte 0 is still in flight from the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            running_reg    <= 1'b0;
            output_pin_reg <= 1'b0;
            first_reg      <= 1'b0;
            div_reg        <= '0;
            div_cnt_reg    <= '0;
            cur_byte_reg   <= '0;
            bit_idx_reg    <= '0;
            byte_idx_reg   <= '0;
        end else if (start_play) begin
            running_reg  <= 1'b1;
            first_reg    <= 1'b1;
            byte_idx_reg <= '0;
            div_reg      <= DIV_W'({rx_data, div_lo_reg});
        end else if (stop_play || finish_play) begin
            running_reg    <= 1'b0;
            output_pin_reg <= 1'b0;
            first_reg      <= 1'b0;
        end else if (running_reg) begin
            if (first_reg) begin
                first_reg      <= 1'b0;
                cur_byte_reg   <= rd_data_reg;
                output_pin_reg <= rd_data_reg[7];
                bit_idx_reg    <= 3'd7;
                div_cnt_reg    <= div_reg;
            end else if (div_cnt_reg != '0) begin
                div_cnt_reg <= div_cnt_reg - DIV_W'(1);
            end else begin
                div_cnt_reg <= div_reg;
                if (bit_idx_reg != 3'd0) begin
                    bit_idx_reg    <= bit_idx_reg - 3'd1;
                    output_pin_reg <= cur_byte_reg[bit_idx_reg - 3'd1];
                end else begin
                    byte_idx_reg   <= next_idx;
                    cur_byte_reg   <= rd_data_reg;
                    output_pin_reg <= rd_data_reg[7];
                    bit_idx_reg    <= 3'd7;
                end
            end
        end
    end

    // Single-entry reply slot; a newer reply replaces an unsent one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg      <= 1'b0;
            pend_data_reg <= '0;
            tx_data_reg   <= '0;
            new_tx_reg    <= 1'b0;
        end else begin
            new_tx_reg <= 1'b0;
            if (pend_reg && !tx_busy) begin
                new_tx_reg  <= 1'b1;
                tx_data_reg <= pend_data_reg;
                pend_reg    <= 1'b0;
            end
            if (reply_valid) begin
                pend_reg      <= 1'b1;
                pend_data_reg <= reply_byte;
            end
        end
    end
endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: a waveform model derived from the buffer contents and
// divider is compared against output_pin/running every cycle; replies are queued and checked.
module tb_pattern_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       new_rx_data = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       new_tx_data, output_pin, running;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // waveform model: what the pin must show t clocks after the first bit appears
    logic [7:0] m_buf [256];
    bit         m_active = 1'b0;
    bit         m_oneshot = 1'b0;
    int         m_c0 = 0, m_div = 0, m_len = 1;

    logic [7:0] ack_q[$];
    logic       prev_ntx = 1'b0;
    logic [15:0] lit;

    pattern_gen dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
        .output_pin(output_pin), .running(running)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        int t, bitnum;
        logic er, ep;
        bit known;
        if (chk_en) begin
            t = cyc - m_c0 - 1;
            er = m_active;
            ep = 1'b0;
            known = 1'b1;
            if (m_active) begin
                if (t < 0)
                    known = 1'b0;
                else if (m_oneshot && t >= 8 * m_len * (m_div + 1))
                    er = 1'b0;
                else begin
                    bitnum = t / (m_div + 1);
                    ep = m_buf[(bitnum / 8) % m_len][7 - (bitnum % 8)];
                end
            end
            chk_bit("model_running", running, er);
            if (known)
                chk_bit("model_output_pin", output_pin, ep);
        end
    end

    always @(negedge clk) begin
        if (chk_en && new_tx_data) begin
            ack_q.push_back(tx_data);
            chk_bit("ack_pulse_1cyc_prev", prev_ntx, 1'b0);
        end
        prev_ntx <= new_tx_data;
    end

    task automatic send(input logic [7:0] b);
        rx_data = b;
        new_rx_data = 1'b1;
        @(posedge clk);
        #1;
        new_rx_data = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pin_at(input int t, input logic exp_pin, input logic exp_run, input string name);
        if (cyc > m_c0 + 1 + t) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: sample point t=%0d already passed (cyc %0d)", name, t, cyc);
        end else begin
            wait_cyc(m_c0 + 1 + t);
            @(negedge clk);
            chk_bit(name, output_pin, exp_pin);
            chk_bit({name, "_running"}, running, exp_run);
        end
    endtask

    task automatic expect_ack(input logic [7:0] exp, input string name);
        int n = 0;
        while (ack_q.size() == 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (ack_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no reply within 40 cycles, expected 0x%0h", name, exp);
        end else begin
            chk_val(name, 32'(ack_q.pop_front()), 32'(exp));
        end
    endtask

    task automatic start_model(input int div, input bit oneshot);
        m_div = div;
        m_oneshot = oneshot;
        m_c0 = cyc;
        m_active = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_tx_data", 32'(tx_data), 32'h0);
        chk_bit("rst_new_tx_data", new_tx_data, 1'b0);
        chk_bit("rst_output_pin", output_pin, 1'b0);
        chk_bit("rst_running", running, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;

        $display("txn: RUN while unloaded");
        send(8'h02); send(8'h00); send(8'h00);
        expect_ack(8'hEE, "run_unloaded");
        repeat (5) @(posedge clk);
        #1;

        $display("txn: unknown 0x7E");
        send(8'h7E);
        expect_ack(8'hEE, "unknown_7e");
`ifndef PATGEN_ONESHOT_EN
        $display("txn: 0x04 without one-shot support");
        send(8'h04);
        expect_ack(8'hEE, "unknown_04");
`endif

        $display("txn: LOAD 2 bytes A5 0F");
        send(8'h01); send(8'h01);
        send(8'hA5); m_buf[0] = 8'hA5;
        send(8'h0F); m_buf[1] = 8'h0F;
        m_len = 2;
        expect_ack(8'hA5, "load2");

        $display("txn: RUN div=3");
        send(8'h02); send(8'h03); send(8'h00);
        start_model(3, 1'b0);
        lit = 16'b1010010100001111;
        for (int k = 0; k < 32; k++)
            pin_at(4 * k + 1, lit[15 - (k % 16)], 1'b1, "loop_bit");
        expect_ack(8'hA5, "run_div3");

        $display("txn: STOP mid-play");
        send(8'h03);
        m_active = 1'b0;
        chk_bit("stop_pin", output_pin, 1'b0);
        chk_bit("stop_running", running, 1'b0);
        expect_ack(8'hA5, "stop");

        $display("txn: RUN div=1 restarts at byte 0 bit 7");
        send(8'h02); send(8'h01); send(8'h00);
        start_model(1, 1'b0);
        pin_at(0, 1'b1, 1'b1, "restart_b7");
        pin_at(2, 1'b0, 1'b1, "restart_b6");
        expect_ack(8'hA5, "rerun");

        $display("txn: LOAD during PLAY with tx_busy held");
        wait_cyc(m_c0 + 32);
        tx_busy = 1'b1;
        send(8'h01);
        m_active = 1'b0;
        chk_bit("load_in_play_pin", output_pin, 1'b0);
        chk_bit("load_in_play_running", running, 1'b0);
        send(8'h00);
        send(8'h3C); m_buf[0] = 8'h3C;
        m_len = 1;
        repeat (10) @(posedge clk);
        #1;
        chk_val("bp_hold", 32'(ack_q.size()), 32'd0);
        tx_busy = 1'b0;
        expect_ack(8'hA5, "bp_release");
        repeat (5) @(posedge clk);
        #1;
        chk_val("bp_single", 32'(ack_q.size()), 32'd0);

        $display("txn: LOAD 256 bytes, RUN div=0");
        send(8'h01); send(8'hFF);
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
            m_buf[i] = 8'(i);
        end
        m_len = 256;
        expect_ack(8'hA5, "load256");
        send(8'h02); send(8'h00); send(8'h00);
        start_model(0, 1'b0);
        pin_at(15, 1'b1, 1'b1, "b256_t15");
        expect_ack(8'hA5, "run256");
        pin_at(2047, 1'b1, 1'b1, "b256_last_bit");
        pin_at(2048, 1'b0, 1'b1, "b256_wrap_bit");
        pin_at(2062, 1'b0, 1'b1, "b256_t2062");
        pin_at(2063, 1'b1, 1'b1, "b256_t2063");
        send(8'h03);
        m_active = 1'b0;
        expect_ack(8'hA5, "stop256");

`ifdef PATGEN_ONESHOT_EN
        $display("txn: ONESHOT 1 byte F0");
        send(8'h01); send(8'h00);
        send(8'hF0); m_buf[0] = 8'hF0;
        m_len = 1;
        expect_ack(8'hA5, "load_f0");
        send(8'h04); send(8'h00); send(8'h00);
        start_model(0, 1'b1);
        for (int t = 0; t < 10; t++)
            pin_at(t, (t < 4), (t < 8), "oneshot");
        expect_ack(8'hA5, "oneshot_start");
        expect_ack(8'hD0, "oneshot_done");
        m_active = 1'b0;
        m_oneshot = 1'b0;
`endif

        repeat (5) @(posedge clk);
        #1;
        chk_val("no_extra_reply", 32'(ack_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
- Signal generator that mirrors the oscilloscope: the oscilloscope samples a pin and streams bytes to the host, while this block takes bytes from the host and replays them bit-serially on a pin.
- Sits beside the oscilloscope on the avr_interface serial channel.
- Consumes rx_data/new_rx_data commands, stores a waveform buffer in block RAM, and plays it out on output_pin at a programmable bit rate.
- Replies with one-byte acknowledgements over tx_data/new_tx_data.

Parameters:
- DEPTH_LOG2, 8, log2 of buffer depth in bytes (256 bytes by default).
- DIV_W, 16, width of the bit-period divider.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from avr_interface
- new_rx_data  in  1  one-cycle strobe; rx_data valid
- tx_data  out  8  byte to transmit
- new_tx_data  out  1  one-cycle strobe; tx_data valid
- tx_busy  in  1  transmitter busy; no strobe while high
- output_pin  out  1  generated waveform
- running  out  1  high while playback is active

Behaviour:
- Reset values: tx_data=0, new_tx_data=0, output_pin=0, running=0, len=0, loaded=0, div=0, state=IDLE, ack pending cleared.
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). Reset mid-load or mid-playback aborts immediately. Buffer RAM contents need not be cleared.
- Command bytes are accepted only in IDLE or PLAY:
  - 0x01 LOAD
  - 0x02 RUN
  - 0x03 STOP
  - any other value is ignored and replies 0xEE.
- LOAD:
  - Entering LOAD from PLAY stops playback in the same cycle: running=0, output_pin=0.
  - State LEN: next byte L gives len=L+1 (1..256; clip to 2^DEPTH_LOG2).
  - State DATA: next len bytes are written to addr 0..len-1.
  - After the last byte: loaded=1, reply 0xA5, go to IDLE.
- RUN:
  - States DIVL, DIVH: capture div[7:0], then div[15:8]. Bit period = div+1 clocks; div=0 gives one bit per clock.
  - If loaded=0, reply 0xEE and return to IDLE.
  - Otherwise reply 0xA5 and enter PLAY.
  - The first bit (bit 7 of byte 0) appears on output_pin 2 clocks after the DIVH byte strobe, allowing 1 cycle of RAM read latency.
- PLAY:
  - Bits go out MSB first.
  - Byte k+1 is prefetched while byte k is shifting, so there are no gaps between bytes.
  - After bit 0 of byte len-1, wraps to byte 0 seamlessly.
  - running=1 for the whole of PLAY.
- RUN received while in PLAY: the new divider takes effect and playback restarts from byte 0.
- STOP: running=0 and output_pin=0 on the next clock, reply 0xA5. STOP in IDLE also replies 0xA5.
- new_rx_data during LEN/DATA/DIVL/DIVH is consumed as an argument, never as a command.
- Ack path:
  - Single-entry pending register.
  - new_tx_data pulses for exactly 1 cycle in the first cycle with tx_busy=0 and a reply pending.
  - tx_data holds its value until the next reply.
  - A new reply arriving while one is pending overwrites it; only the latest is sent.
- Divider counter: DIV_W bits, counts div down to 0, then advances the bit. No overflow is possible.

Optional Feature:
- Macro: PATGEN_ONESHOT_EN.
- Defined: command 0x04 ONESHOT takes two divider bytes exactly like RUN.
  - Plays the buffer once with no wrap.
  - After the final bit: output_pin=0, running=0, reply 0xD0, return to IDLE.
  - loaded=0 gives reply 0xEE, exactly as for RUN.
- Not defined: 0x04 is an unknown command and replies 0xEE; no one-shot logic is synthesised.

Test Plan:
- Reset then RUN: apply rst, then send 0x02,0x00,0x00 -> reply 0xEE, running stays 0, output_pin stays 0.
- LOAD and loop:
  - Send 0x01,0x01,0xA5,0x0F -> reply 0xA5.
  - Then send 0x02,0x03,0x00 -> reply 0xA5. From 2 clocks after the last byte, output_pin shows 1010010100001111, each bit held 4 clocks.
  - Pattern repeats with no gap at the wrap.
- STOP mid-play: during playback send 0x03 -> output_pin=0 and running=0 one clock later, reply 0xA5; a later RUN restarts from byte 0, bit 7.
- Ack back-pressure:
  - Hold tx_busy=1 while completing a LOAD -> new_tx_data stays 0.
  - Release tx_busy -> a single 1-cycle pulse with tx_data=0xA5.
  - Unknown byte 0x7E in IDLE -> reply 0xEE.
- Boundary cases:
  - LOAD with L=0xFF and div=0: 256 bytes, 2048 bits play at 1 bit/clk; byte 255 bit 0 is followed directly by byte 0 bit 7.
  - LOAD sent during PLAY stops output in the same cycle.
- With PATGEN_ONESHOT_EN: load 1 byte 0xF0, send 0x04,0x00,0x00 -> 11110000 plays once, then output_pin=0, running=0, reply 0xD0.
